// File: rtl/wb_irq_router.sv
// Wishbone-slave interrupt router. Each source has programmable enable, polarity,
// level/edge mode and target line. The sources drive a registered 32-bit CPU irq vector.
module wb_irq_router #(
    parameter int NUM_SRC     = 8,
    parameter int SYNC_STAGES = 2,
    parameter int ROUTE_BASE  = 2
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic [7:0]         wb_adr_i,
    input  logic [31:0]        wb_dat_i,
    input  logic [3:0]         wb_sel_i,
    input  logic               wb_we_i,
    input  logic               wb_cyc_i,
    input  logic               wb_stb_i,
    output logic [31:0]        wb_dat_o,
    output logic               wb_ack_o,
    input  logic [NUM_SRC-1:0] src_i,
    output logic [31:0]        irq_o
);

    localparam logic [5:0] ADR_STATUS  = 6'h00;
    localparam logic [5:0] ADR_PENDING = 6'h01;
    localparam logic [5:0] ADR_ENABLE  = 6'h02;
    localparam logic [5:0] ADR_EDGE    = 6'h03;
    localparam logic [5:0] ADR_POL     = 6'h04;
    localparam logic [5:0] ADR_ROUTE   = 6'h10;

    logic               ack_q, ack_d;
    logic [31:0]        dat_q, dat_d;
    logic [5:0]         adr_q, adr_d;
    logic [31:0]        wdat_q, wdat_d;
    logic               we_q, we_d;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] enable_q, enable_d;
    logic [NUM_SRC-1:0] edge_mode_q, edge_mode_d;
    logic [NUM_SRC-1:0] pol_q, pol_d;
    logic [NUM_SRC-1:0] prev_s_q, prev_s_d;
    logic [4:0]         route_q [NUM_SRC];
    logic [4:0]         route_d [NUM_SRC];
    logic [31:0]        irq_q, irq_d;

    logic               req;
    logic               wr_commit;
    logic [31:0]        rd_data;
    logic [NUM_SRC-1:0] src_s;
    logic [NUM_SRC-1:0] s;
    logic [NUM_SRC-1:0] w1c;
    logic               unused_ok;

    assign unused_ok = ^{wb_sel_i, wb_adr_i[1:0], wdat_q};

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign src_s = src_i;
        end else begin : g_sync
            logic [NUM_SRC-1:0] sync_q [SYNC_STAGES];
            logic [NUM_SRC-1:0] sync_d [SYNC_STAGES];

            always_comb begin
                sync_d[0] = src_i;
                for (int j = 1; j < SYNC_STAGES; j++) begin
                    sync_d[j] = sync_q[j-1];
                end
            end

            always_ff @(posedge wb_clk_i) begin
                if (wb_rst_i) begin
                    for (int j = 0; j < SYNC_STAGES; j++) begin
                        sync_q[j] <= '0;
                    end
                end else begin
                    sync_q <= sync_d;
                end
            end

            assign src_s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    // Handshake: a request is cyc&stb while ack is low. It is acked one cycle later, for one cycle.
    // Read data is captured at the request edge. Writes commit at the edge that ends the ack cycle.
    assign req       = wb_cyc_i & wb_stb_i & ~ack_q;
    assign wr_commit = ack_q & we_q;

    always_comb begin
        rd_data = '0;
        case (wb_adr_i[7:2])
            ADR_STATUS:  rd_data = 32'(pending_q & enable_q);
            ADR_PENDING: rd_data = 32'(pending_q);
            ADR_ENABLE:  rd_data = 32'(enable_q);
            ADR_EDGE:    rd_data = 32'(edge_mode_q);
            ADR_POL:     rd_data = 32'(pol_q);
            default:     rd_data = '0;
        endcase
        for (int i = 0; i < NUM_SRC; i++) begin
            if (wb_adr_i[7:2] == ADR_ROUTE + 6'(i)) begin
                rd_data = {27'd0, route_q[i]};
            end
        end
    end

    always_comb begin
        ack_d  = req;
        dat_d  = req ? rd_data : '0;
        adr_d  = req ? wb_adr_i[7:2] : adr_q;
        wdat_d = req ? wb_dat_i : wdat_q;
        we_d   = req ? wb_we_i : we_q;
    end

    always_comb begin
        enable_d    = enable_q;
        edge_mode_d = edge_mode_q;
        pol_d       = pol_q;
        route_d     = route_q;
        w1c         = '0;
        if (wr_commit) begin
            case (adr_q)
                ADR_PENDING: w1c         = wdat_q[NUM_SRC-1:0];
                ADR_ENABLE:  enable_d    = wdat_q[NUM_SRC-1:0];
                ADR_EDGE:    edge_mode_d = wdat_q[NUM_SRC-1:0];
                ADR_POL:     pol_d       = wdat_q[NUM_SRC-1:0];
                default:     w1c         = '0;
            endcase
            for (int i = 0; i < NUM_SRC; i++) begin
                if (adr_q == ADR_ROUTE + 6'(i)) begin
                    route_d[i] = wdat_q[4:0];
                end
            end
        end
    end

    // A newly detected edge wins over a simultaneous W1C. Flipping a source's mode discards its pending bit.
    always_comb begin
        s         = src_s ^ pol_q;
        prev_s_d  = s;
        pending_d = (edge_mode_q & ((s & ~prev_s_q) | (pending_q & ~w1c)))
                  | (~edge_mode_q & s);
        pending_d = pending_d & ~(edge_mode_d ^ edge_mode_q);
    end

    always_comb begin
        irq_d = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (pending_q[i] && enable_q[i]) begin
                irq_d[route_q[i]] = 1'b1;
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ack_q       <= 1'b0;
            dat_q       <= '0;
            adr_q       <= '0;
            wdat_q      <= '0;
            we_q        <= 1'b0;
            pending_q   <= '0;
            enable_q    <= '0;
            edge_mode_q <= '0;
            pol_q       <= '0;
            prev_s_q    <= '0;
            irq_q       <= '0;
            for (int i = 0; i < NUM_SRC; i++) begin
                route_q[i] <= 5'((ROUTE_BASE + i) % 32);
            end
        end else begin
            ack_q       <= ack_d;
            dat_q       <= dat_d;
            adr_q       <= adr_d;
            wdat_q      <= wdat_d;
            we_q        <= we_d;
            pending_q   <= pending_d;
            enable_q    <= enable_d;
            edge_mode_q <= edge_mode_d;
            pol_q       <= pol_d;
            prev_s_q    <= prev_s_d;
            irq_q       <= irq_d;
            route_q     <= route_d;
        end
    end

    assign wb_ack_o = ack_q;
    assign wb_dat_o = dat_q;
    assign irq_o    = irq_q;

endmodule

// File: tb/tb_wb_irq_router.sv
// Self-checking bench for wb_irq_router: register table, directed timing sequences,
// and randomized sources checked against a behavioural interrupt model.
`timescale 1ns/1ps
module tb_wb_irq_router;

    localparam int NUM_SRC     = 8;
    localparam int SYNC_STAGES = 2;
    localparam int ROUTE_BASE  = 2;

    logic               clk;
    logic               wb_rst_i;
    logic [7:0]         wb_adr_i;
    logic [31:0]        wb_dat_i;
    logic [3:0]         wb_sel_i;
    logic               wb_we_i;
    logic               wb_cyc_i;
    logic               wb_stb_i;
    logic [31:0]        wb_dat_o;
    logic               wb_ack_o;
    logic [NUM_SRC-1:0] src_i;
    logic [31:0]        irq_o;

    wb_irq_router #(
        .NUM_SRC    (NUM_SRC),
        .SYNC_STAGES(SYNC_STAGES),
        .ROUTE_BASE (ROUTE_BASE)
    ) dut (
        .wb_clk_i(clk),
        .wb_rst_i(wb_rst_i),
        .wb_adr_i(wb_adr_i),
        .wb_dat_i(wb_dat_i),
        .wb_sel_i(wb_sel_i),
        .wb_we_i (wb_we_i),
        .wb_cyc_i(wb_cyc_i),
        .wb_stb_i(wb_stb_i),
        .wb_dat_o(wb_dat_o),
        .wb_ack_o(wb_ack_o),
        .src_i   (src_i),
        .irq_o   (irq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic        we;
        logic [7:0]  adr;
        logic [31:0] wdat;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[$];

    // Behavioural model state for the randomized rounds.
    logic [NUM_SRC-1:0] m_en;
    logic [NUM_SRC-1:0] m_edge;
    logic [NUM_SRC-1:0] m_pol;
    logic [4:0]         m_route [NUM_SRC];
    logic [NUM_SRC-1:0] hist[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic bus_idle();
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
        wb_adr_i = '0;
        wb_dat_i = '0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        wb_rst_i = 1'b1;
        bus_idle();
        src_i = '0;
        repeat (2) @(posedge clk);
        #1;
        wb_rst_i = 1'b0;
    endtask

    task automatic bus_xfer(input logic we, input logic [7:0] adr, input logic [31:0] wdat,
                            output logic [31:0] rdat, output logic got_ack);
        @(posedge clk); #1;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = we;
        wb_adr_i = adr;
        wb_dat_i = wdat;
        got_ack  = 1'b0;
        rdat     = '0;
        for (int n = 0; n < 8; n++) begin
            if (!got_ack) begin
                @(posedge clk); #1;
                if (wb_ack_o) begin
                    got_ack = 1'b1;
                    rdat    = wb_dat_o;
                end
            end
        end
        bus_idle();
    endtask

    task automatic wb_write(input logic [7:0] adr, input logic [31:0] dat);
        logic [31:0] rd;
        logic        ok;
        bus_xfer(1'b1, adr, dat, rd, ok);
        check($sformatf("wr_ack_%02h", adr), 32'(ok), 32'd1);
    endtask

    task automatic wb_read(input logic [7:0] adr, output logic [31:0] dat);
        logic ok;
        bus_xfer(1'b0, adr, 32'h0, dat, ok);
        check($sformatf("rd_ack_%02h", adr), 32'(ok), 32'd1);
    endtask

    task automatic read_check(input string name, input logic [7:0] adr, input logic [31:0] exp);
        logic [31:0] rd;
        wb_read(adr, rd);
        check(name, rd, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic ss(int t, int i);
        if (t < 0) return m_pol[i];
        return hist[t][i] ^ m_pol[i];
    endfunction

    // irq_o after clock edge e depends on the source value driven SYNC_STAGES+2 edges earlier.
    function automatic logic [31:0] model_irq(int e);
        logic [31:0] v;
        logic        act;
        int          last;
        v    = '0;
        last = e - 2 - SYNC_STAGES;
        for (int i = 0; i < NUM_SRC; i++) begin
            act = 1'b0;
            if (m_edge[i]) begin
                for (int t = 0; t <= last; t++) begin
                    if (ss(t, i) && !ss(t - 1, i)) act = 1'b1;
                end
            end else begin
                act = ss(last, i);
            end
            if (act && m_en[i]) v[m_route[i]] = 1'b1;
        end
        return v;
    endfunction

    task automatic random_round(input int cycles);
        do_reset();
        m_pol  = NUM_SRC'($urandom);
        m_edge = NUM_SRC'($urandom);
        m_en   = NUM_SRC'($urandom);
        wb_write(8'h10, 32'(m_pol));
        for (int i = 0; i < NUM_SRC; i++) begin
            m_route[i] = 5'($urandom_range(0, 11));
            wb_write(8'h40 + 8'(4 * i), {27'd0, m_route[i]});
        end
        wb_write(8'h0C, 32'(m_edge));
        wb_write(8'h08, 32'(m_en));
        idle(8);
        hist.delete();
        for (int n = 0; n < cycles; n++) begin
            @(posedge clk); #1;
            check($sformatf("rand_irq_e%0d", n), irq_o, model_irq(n));
            if ($urandom_range(0, 3) == 0) src_i = NUM_SRC'($urandom);
            hist.push_back(src_i);
        end
        src_i = '0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        ok;

        wb_rst_i = 1'b1;
        wb_sel_i = 4'hF;
        src_i    = '0;
        bus_idle();

        tbl.push_back('{1'b0, 8'h00, 32'h0,         32'h0});
        tbl.push_back('{1'b0, 8'h04, 32'h0,         32'h0});
        tbl.push_back('{1'b0, 8'h08, 32'h0,         32'h0});
        tbl.push_back('{1'b0, 8'h0C, 32'h0,         32'h0});
        tbl.push_back('{1'b0, 8'h10, 32'h0,         32'h0});
        tbl.push_back('{1'b0, 8'h40, 32'h0,         32'h2});
        tbl.push_back('{1'b0, 8'h44, 32'h0,         32'h3});
        tbl.push_back('{1'b0, 8'h5C, 32'h0,         32'h9});
        tbl.push_back('{1'b0, 8'h60, 32'h0,         32'h0});
        tbl.push_back('{1'b0, 8'h14, 32'h0,         32'h0});
        tbl.push_back('{1'b1, 8'h08, 32'hFFFF_FFFF, 32'h0});
        tbl.push_back('{1'b0, 8'h08, 32'h0,         32'hFF});
        tbl.push_back('{1'b1, 8'h0C, 32'h0000_00A5, 32'h0});
        tbl.push_back('{1'b0, 8'h0C, 32'h0,         32'hA5});
        tbl.push_back('{1'b1, 8'h40, 32'hFFFF_FFE7, 32'h0});
        tbl.push_back('{1'b0, 8'h40, 32'h0,         32'h7});
        tbl.push_back('{1'b1, 8'h20, 32'h1234_5678, 32'h0});
        tbl.push_back('{1'b0, 8'h20, 32'h0,         32'h0});
        tbl.push_back('{1'b1, 8'h00, 32'h0000_00FF, 32'h0});
        tbl.push_back('{1'b0, 8'h00, 32'h0,         32'h0});
        tbl.push_back('{1'b0, 8'h43, 32'h0,         32'h7});
        tbl.push_back('{1'b1, 8'h0C, 32'h0,         32'h0});
        tbl.push_back('{1'b0, 8'h0C, 32'h0,         32'h0});
        tbl.push_back('{1'b1, 8'h10, 32'h0000_000F, 32'h0});
        tbl.push_back('{1'b0, 8'h10, 32'h0,         32'hF});
        tbl.push_back('{1'b0, 8'h04, 32'h0,         32'hF});
        tbl.push_back('{1'b0, 8'h00, 32'h0,         32'hF});
        tbl.push_back('{1'b1, 8'h04, 32'h0000_000F, 32'h0});
        tbl.push_back('{1'b0, 8'h04, 32'h0,         32'hF});

        // Reset state and irq_o quiet with everything disabled.
        do_reset();
        check("rst_ack", 32'(wb_ack_o), 32'd0);
        check("rst_dat", wb_dat_o, 32'd0);
        check("rst_irq", irq_o, 32'd0);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            src_i = ~src_i;
            check($sformatf("quiet_irq_c%0d", c), irq_o, 32'd0);
        end
        src_i = '0;
        idle(5);

        // Register table.
        for (int k = 0; k < tbl.size(); k++) begin
            bus_xfer(tbl[k].we, tbl[k].adr, tbl[k].wdat, rd, ok);
            check($sformatf("tbl%0d_ack", k), 32'(ok), 32'd1);
            if (!tbl[k].we) check($sformatf("tbl%0d_rd_%02h", k, tbl[k].adr), rd, tbl[k].exp);
            @(posedge clk); #1;
            check($sformatf("tbl%0d_idle_dat", k), wb_dat_o, 32'd0);
            check($sformatf("tbl%0d_idle_ack", k), 32'(wb_ack_o), 32'd0);
            idle(2);
        end

        // Level mode latency.
        do_reset();
        wb_write(8'h08, 32'h1);
        idle(3);
        src_i[0] = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            check($sformatf("lvl_rise_k%0d", k), irq_o, (k == 4) ? 32'h4 : 32'h0);
        end
        idle(3);
        src_i[0] = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            check($sformatf("lvl_fall_k%0d", k), irq_o, (k == 4) ? 32'h0 : 32'h4);
        end

        // Edge mode latch and W1C clear timing.
        do_reset();
        wb_write(8'h0C, 32'h2);
        wb_write(8'h08, 32'h2);
        idle(3);
        src_i[1] = 1'b1;
        @(posedge clk); #1;
        src_i[1] = 1'b0;
        for (int k = 2; k <= 4; k++) begin
            @(posedge clk); #1;
            check($sformatf("edge_set_k%0d", k), irq_o, (k == 4) ? 32'h8 : 32'h0);
        end
        idle(5);
        check("edge_hold", irq_o, 32'h8);
        wb_write(8'h04, 32'h2);
        check("w1c_ack_cycle", irq_o, 32'h8);
        @(posedge clk); #1;
        check("w1c_plus1", irq_o, 32'h8);
        @(posedge clk); #1;
        check("w1c_plus2", irq_o, 32'h0);
        idle(3);

        // W1C committed on the same edge as a fresh rising edge.
        src_i[1] = 1'b1;
        wb_write(8'h04, 32'h2);
        idle(3);
        read_check("w1c_vs_edge_pend", 8'h04, 32'h2);
        check("w1c_vs_edge_irq", irq_o, 32'h8);

        // Changing EDGE clears pending.
        wb_write(8'h0C, 32'h0);
        idle(4);
        read_check("to_level_pend", 8'h04, 32'h2);
        wb_write(8'h0C, 32'h2);
        idle(4);
        read_check("to_edge_pend", 8'h04, 32'h0);
        check("to_edge_irq", irq_o, 32'h0);
        src_i = '0;

        // Shared routing and polarity.
        do_reset();
        wb_write(8'h40, 32'd10);
        wb_write(8'h44, 32'd10);
        wb_write(8'h08, 32'h3);
        wb_write(8'h10, 32'h1);
        idle(4);
        check("pol_irq10", irq_o, 32'h400);
        read_check("pol_pend", 8'h04, 32'h1);
        wb_write(8'h10, 32'h0);
        src_i[1] = 1'b1;
        idle(6);
        check("share_src1_irq10", irq_o, 32'h400);
        read_check("share_pend", 8'h04, 32'h2);
        src_i[1] = 1'b0;
        idle(6);
        check("share_none_irq", irq_o, 32'h0);

        // Held cyc: ack every other cycle.
        do_reset();
        @(posedge clk); #1;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = 1'b1;
        wb_adr_i = 8'h08;
        wb_dat_i = 32'h5A;
        for (int c = 1; c <= 5; c++) begin
            if (c > 1) begin
                @(posedge clk); #1;
            end
            check($sformatf("held_ack_c%0d", c), 32'(wb_ack_o), (c == 2 || c == 4) ? 32'd1 : 32'd0);
        end
        @(posedge clk); #1;
        bus_idle();
        idle(3);
        read_check("held_enable", 8'h08, 32'h5A);

        // Reset during a transfer drops it and restores defaults.
        wb_write(8'h10, 32'h3);
        wb_write(8'h0C, 32'h4);
        wb_write(8'h40, 32'h1F);
        @(posedge clk); #1;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = 1'b1;
        wb_adr_i = 8'h08;
        wb_dat_i = 32'hFF;
        #1;
        wb_rst_i = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_ack0", 32'(wb_ack_o), 32'd0);
        bus_idle();
        wb_rst_i = 1'b0;
        @(posedge clk); #1;
        check("rst_mid_ack1", 32'(wb_ack_o), 32'd0);
        check("rst_mid_irq", irq_o, 32'd0);
        read_check("rst_mid_enable", 8'h08, 32'h0);
        read_check("rst_mid_edge", 8'h0C, 32'h0);
        read_check("rst_mid_pol", 8'h10, 32'h0);
        read_check("rst_mid_route0", 8'h40, 32'h2);
        read_check("rst_mid_route1", 8'h44, 32'h3);

        // Randomized sources against the behavioural model.
        for (int r = 0; r < 4; r++) begin
            random_round(80);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
